// File: rtl/fsk4_mod_tx.sv
// fsk4_mod_tx -- 4-level FSK baseband symbol mapper and sample generator.
//
// A frame consists of PRE_LEN preamble symbols (+3, -3, ...), then the source
// dibits (Gray-mapped onto +/-LVL and +/-3*LVL), then one zero-level tail
// symbol. Each symbol lasts 2**SPS_LOG2 samples. The datapath advances only
// on cycles where the sample-rate strobe ce is high.
//
// Optional feature macro: FSK4_TX_RAMP_EN
//   defined   -> each symbol ramps linearly from the previous level to its
//                own level, landing exactly on the target at its last sample
//   undefined -> NRZ hold: every sample of a symbol equals its level
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous reset, active low
//   ce         sample-rate strobe
//   sym_valid  source offers a symbol
//   sym        dibit to transmit
//   sym_last   offered symbol ends the frame
//   sym_ready  symbol accepted when sym_valid & sym_ready (combinational)
//   x          signed 16-bit baseband sample (registered)
//   x_valid    one-cycle pulse following each ce while a frame is active
//   busy       a frame is in progress
//   underrun   one-cycle pulse when a data slot finds no symbol offered
module fsk4_mod_tx #(
  parameter int SPS_LOG2 = 2,
  parameter int LVL      = 448,
  parameter int PRE_LEN  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        sym_valid,
  input  logic [1:0]  sym,
  input  logic        sym_last,
  output logic        sym_ready,
  output logic [15:0] x,
  output logic        x_valid,
  output logic        busy,
  output logic        underrun
);

  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;

  localparam logic [SPS_LOG2-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(PRE_LEN - 1);
  localparam logic signed [15:0]  L1       = 16'(LVL);
  localparam logic signed [15:0]  L3       = 16'(3 * LVL);

  typedef enum logic [1:0] {IDLE, PRE, DATA, TAIL} state_t;

  state_t               state;
  logic [SPS_LOG2-1:0]  cnt;
  logic [PW-1:0]        pre_cnt;
  logic signed [15:0]   cur;
  logic                 last_acc;   // last symbol of the frame already taken
  logic signed [15:0]   next_x;

  // Gray mapping: 00 -> -3, 01 -> -1, 11 -> +1, 10 -> +3 (times LVL).
  function automatic logic signed [15:0] level(input logic [1:0] d);
    unique case (d)
      2'b00:   level = -L3;
      2'b01:   level = -L1;
      2'b11:   level = L1;
      default: level = L3;
    endcase
  endfunction

  // A slot is the last sample of a symbol: the only point where the next
  // symbol level is chosen.
  logic slot;
  assign slot      = ce && (cnt == CNT_MAX);
  assign sym_ready = slot && ((state == PRE && pre_cnt == PRE_LAST) ||
                              (state == DATA && !last_acc));
  assign busy      = (state != IDLE);

`ifdef FSK4_TX_RAMP_EN
  logic signed [15:0] prev;
  logic signed [15:0] diff;
  logic signed [15:0] prod;
  logic signed [15:0] k1;

  // prev + (cur - prev)*(k+1)/SPS; at k = SPS-1 the fraction is exactly 1,
  // so every symbol ends precisely on its target level.
  always_comb begin
    k1     = 16'(cnt) + 16'sd1;
    diff   = cur - prev;
    prod   = diff * k1;
    next_x = prev + (prod >>> SPS_LOG2);
  end
`else
  always_comb next_x = cur;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      pre_cnt  <= '0;
      cur      <= '0;
`ifdef FSK4_TX_RAMP_EN
      prev     <= '0;
`endif
      last_acc <= 1'b0;
      x        <= '0;
      x_valid  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      x_valid  <= 1'b0;
      underrun <= 1'b0;
      if (ce) begin
        if (state == IDLE) begin
          // Start of frame: nothing is consumed, the first preamble symbol
          // begins on the next ce.
          if (sym_valid) begin
            state    <= PRE;
            cnt      <= '0;
            pre_cnt  <= '0;
            cur      <= L3;
`ifdef FSK4_TX_RAMP_EN
            prev     <= '0;
`endif
            last_acc <= 1'b0;
          end
        end else begin
          x_valid <= 1'b1;
          x       <= next_x;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_MAX) begin
`ifdef FSK4_TX_RAMP_EN
            prev <= cur;
`endif
            unique case (state)
              PRE: begin
                if (pre_cnt == PRE_LAST) begin
                  state <= DATA;
                  if (sym_valid) begin
                    cur      <= level(sym);
                    last_acc <= sym_last;
                  end else begin
                    cur      <= '0;
                    underrun <= 1'b1;
                  end
                end else begin
                  pre_cnt <= pre_cnt + 1'b1;
                  cur     <= -cur;
                end
              end
              DATA: begin
                if (last_acc) begin
                  state <= TAIL;
                  cur   <= '0;
                end else if (sym_valid) begin
                  cur      <= level(sym);
                  last_acc <= sym_last;
                end else begin
                  cur      <= '0;
                  underrun <= 1'b1;
                end
              end
              default: begin
                // TAIL has landed on 0; the next frame ramps from 0.
                state <= IDLE;
                cur   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fsk4_mod_tx.sv
module tb_fsk4_mod_tx;

  localparam int SPS_LOG2 = 2;
  localparam int SPS      = 1 << SPS_LOG2;
  localparam int LVL      = 448;
  localparam int PRE_LEN  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        sym_valid;
  logic [1:0]  sym;
  logic        sym_last;
  logic        sym_ready;
  logic [15:0] x;
  logic        x_valid;
  logic        busy;
  logic        underrun;

  fsk4_mod_tx #(.SPS_LOG2(SPS_LOG2), .LVL(LVL), .PRE_LEN(PRE_LEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .sym_valid (sym_valid),
    .sym       (sym),
    .sym_last  (sym_last),
    .sym_ready (sym_ready),
    .x         (x),
    .x_valid   (x_valid),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Frame-level reference model: a list of symbol levels per frame and a
  // running count of ce samples; each sample is derived from its symbol.
  bit in_frame = 0;
  bit last_acc = 0;
  int n        = 0;
  int end_sym  = -1;
  int exp_x    = 0;
  int lv[$];
  int xq[$];

  function automatic int level_of(input logic [1:0] d);
    case (d)
      2'b00:   return -3 * LVL;
      2'b01:   return -LVL;
      2'b11:   return LVL;
      default: return 3 * LVL;
    endcase
  endfunction

  function automatic int sample_at(input int s, input int k);
    int cur_l, prv_l;
    cur_l = lv[s];
    prv_l = (s == 0) ? 0 : lv[s-1];
`ifdef FSK4_TX_RAMP_EN
    return prv_l + (((cur_l - prv_l) * (k + 1)) >>> SPS_LOG2);
`else
    return cur_l + 0 * prv_l;
`endif
  endfunction

  // One clock cycle: drive inputs at posedge+1, check sym_ready, then check
  // registered outputs at the following posedge+1.
  task automatic cycle(input bit c, input bit req, input logic [1:0] d,
                       input bit last, output bit acc);
    int s, k, nx;
    bit exp_rdy, exp_und, exp_xv, start_f, end_f;
    exp_rdy = 0; exp_und = 0; start_f = 0; end_f = 0; acc = 0;
    ce = c; sym = d; sym_last = last;
    exp_xv = c && in_frame;
    nx = exp_x;
    if (!in_frame) begin
      sym_valid = req;
      start_f   = c && req;
    end else begin
      s = n / SPS;
      k = n % SPS;
      if (k == SPS - 1 && s >= PRE_LEN - 1 && !last_acc) begin
        sym_valid = req;
        exp_rdy   = c;
      end else begin
        sym_valid = 1'($urandom);
      end
      if (c) begin
        nx = sample_at(s, k);
        if (exp_rdy) begin
          if (req) begin
            acc = 1;
            lv.push_back(level_of(d));
            if (last) begin
              last_acc = 1;
              lv.push_back(0);
              end_sym = s + 2;
            end
          end else begin
            lv.push_back(0);
            exp_und = 1;
          end
        end
        if (last_acc && s == end_sym && k == SPS - 1) end_f = 1;
        n++;
      end
    end
    #1;
    check("sym_ready", sym_ready, exp_rdy);
    @(posedge clk);
    #1;
    exp_x = nx;
    if (start_f) begin
      in_frame = 1; n = 0; last_acc = 0; end_sym = -1;
      lv.delete();
      for (int i = 0; i < PRE_LEN; i++) lv.push_back((i % 2 == 0) ? 3 * LVL : -3 * LVL);
    end
    if (end_f) in_frame = 0;
    if (x_valid) xq.push_back(int'($signed(x)));
    check("x", int'($signed(x)), exp_x);
    check("x_valid", x_valid, exp_xv);
    check("busy", busy, in_frame);
    check("underrun", underrun, exp_und);
  endtask

  task automatic do_reset();
    reset = 1'b0; ce = 1'b1; sym_valid = 1'b1; sym_last = 1'b0;
    #1;
    check("rst_x", int'($signed(x)), 0);
    check("rst_busy", busy, 0);
    check("rst_x_valid", x_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_sym_ready", sym_ready, 0);
    in_frame = 0; last_acc = 0; n = 0; end_sym = -1; exp_x = 0;
    lv.delete();
    @(posedge clk);
    #1;
    check("rst_hold_x", int'($signed(x)), 0);
    check("rst_hold_busy", busy, 0);
    reset = 1'b1; ce = 1'b0; sym_valid = 1'b0;
  endtask

  // cep: 0 = random ce, otherwise ce every cep cycles.
  task automatic run_frame(input int ndata, input int cep, input int und_pct,
                           input bit fixed, input int abort_sym);
    int sent, cyc;
    bit c, acc, req;
    logic [1:0] d;
    sent = 0; cyc = 0;
    while (!in_frame && cyc < 50) begin
      c = (cep == 0) ? ($urandom_range(0, 2) != 0) : (cyc % cep == 0);
      cycle(c, 1'b1, 2'b00, 1'b0, acc);
      cyc++;
    end
    check("frame_started", in_frame, 1);
    while (in_frame && cyc < 3000) begin
      if (abort_sym >= 0 && n == abort_sym * SPS + 1) begin
        do_reset();
        return;
      end
      c   = (cep == 0) ? ($urandom_range(0, 2) != 0) : (cyc % cep == 0);
      req = ($urandom_range(0, 99) >= und_pct);
      d   = fixed ? ((sent == 0) ? 2'b10 : 2'b00) : 2'($urandom);
      cycle(c, req, d, sent == ndata - 1, acc);
      if (acc) sent++;
      cyc++;
    end
    check("frame_done", in_frame, 0);
  endtask

  task automatic idle_cycles(input int cnt);
    bit acc;
    for (int i = 0; i < cnt; i++) cycle(1'($urandom), 1'b0, 2'b00, 1'b0, acc);
  endtask

  int e5[5];

  initial begin
    reset = 1'b0; ce = 1'b0; sym_valid = 1'b0; sym = 2'b00; sym_last = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle_cycles(3);

    // Directed frame: ce every cycle, dibits 10, 00, last on the second.
`ifdef FSK4_TX_RAMP_EN
    e5 = '{336, 672, 1008, 1344, 672};
`else
    e5 = '{1344, 1344, 1344, 1344, -1344};
`endif
    xq.delete();
    run_frame(2, 1, 0, 1'b1, -1);
    check("n_samples", xq.size(), (PRE_LEN + 3) * SPS);
    if (xq.size() >= (PRE_LEN + 3) * SPS) begin
      for (int i = 0; i < 5; i++) check("pre_sample", xq[i], e5[i]);
      check("data0_end", xq[PRE_LEN * SPS + SPS - 1], 3 * LVL);
      check("data1_end", xq[PRE_LEN * SPS + 2 * SPS - 1], -3 * LVL);
      check("tail_end", xq[PRE_LEN * SPS + 3 * SPS - 1], 0);
    end
    idle_cycles(2);

    // ce every third cycle, random data.
    run_frame(4, 3, 0, 1'b0, -1);
    idle_cycles(2);

    // Frequent underruns.
    run_frame(5, 1, 40, 1'b0, -1);
    idle_cycles(2);

    // Reset during the second sample of a data symbol, then a clean restart.
    run_frame(4, 1, 0, 1'b0, PRE_LEN + 1);
    idle_cycles(2);
    run_frame(2, 1, 0, 1'b0, -1);
    idle_cycles(2);

    // Randomized frames.
    for (int f = 0; f < 14; f++) begin
      run_frame($urandom_range(1, 6), $urandom_range(0, 3), $urandom_range(0, 25),
                1'b0, -1);
      idle_cycles($urandom_range(0, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
